// File: rtl/hist_rmw_ram.sv
// Histogram RAM: pipelined read-modify-write increment stream, host word access and
// a hardware clear sequencer. The array has one read port and one write port so a
// sample can be read and an older sample written back in the same cycle.
module hist_rmw_ram #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INC_W  = 8,
    parameter int unsigned SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_bin,
    input  logic [INC_W-1:0]  in_inc,
    input  logic              host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [DATA_W-1:0] host_writedata,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_readdatavalid,
    input  logic              clear_req,
    output logic              busy,
    output logic              ovf_sticky
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned ZextW = DATA_W + 1 - INC_W;

    typedef enum logic [1:0] {StStream, StDrain, StHost, StClear} state_e;

    state_e            state_q;
    state_e            target_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              ovf_q;
    logic              rd_pend_q;
    logic              rdv_q;
    logic [DATA_W-1:0] rdata_q;

    // Stage B: RAM q valid for this sample; stage C: write-back; stage D: last written.
    logic              b_valid_q;
    logic [ADDR_W-1:0] b_bin_q;
    logic [INC_W-1:0]  b_inc_q;
    logic              c_valid_q;
    logic [ADDR_W-1:0] c_bin_q;
    logic [DATA_W-1:0] c_sum_q;
    logic              d_valid_q;
    logic [ADDR_W-1:0] d_bin_q;
    logic [DATA_W-1:0] d_sum_q;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] ram_q;

    logic              accept;
    logic              host_rd;
    logic              host_wr;
    logic              pipe_empty;
    logic [DATA_W-1:0] base;
    logic [DATA_W:0]   sum_full;
    logic              carry;
    logic [DATA_W-1:0] sum;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;

    assign in_ready           = (state_q == StStream) && !rst;
    assign accept             = in_valid && in_ready;
    // A simultaneous read and write performs only the write.
    assign host_rd            = (state_q == StHost) && host_read && !host_write;
    assign host_wr            = (state_q == StHost) && host_write;
    assign pipe_empty         = !b_valid_q && !c_valid_q;
    assign host_waitrequest   = (state_q != StHost) || rst;
    assign busy               = (state_q == StClear) || accept || !pipe_empty;
    assign host_readdata      = rdata_q;
    assign host_readdatavalid = rdv_q;
    assign ovf_sticky         = ovf_q;
    assign ram_raddr          = (state_q == StHost) ? host_addr : in_bin;

    // Forward in-flight results for the bin in B, then add with overflow handling.
    always_comb begin
        base = ram_q;
        if (c_valid_q && (c_bin_q == b_bin_q)) begin
            base = c_sum_q;
        end else if (d_valid_q && (d_bin_q == b_bin_q)) begin
            base = d_sum_q;
        end
        sum_full = {1'b0, base} + {{ZextW{1'b0}}, b_inc_q};
        carry    = sum_full[DATA_W];
        if (carry && (SAT != 0)) begin
            sum = '1;
        end else begin
            sum = sum_full[DATA_W-1:0];
        end
    end

    // Write-port arbitration; nothing is written while reset is asserted.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = c_bin_q;
        ram_wdata = c_sum_q;
        if (state_q == StClear) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
        end else if (host_wr) begin
            ram_we    = 1'b1;
            ram_waddr = host_addr;
            ram_wdata = host_writedata;
        end else if (c_valid_q) begin
            ram_we = 1'b1;
        end
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    // Bin storage: synchronous read returns the old word on a same-address write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_q <= mem[ram_raddr];
    end

    // Increment pipeline registers B -> C -> D.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_bin_q   <= '0;
            b_inc_q   <= '0;
            c_valid_q <= 1'b0;
            c_bin_q   <= '0;
            c_sum_q   <= '0;
            d_valid_q <= 1'b0;
            d_bin_q   <= '0;
            d_sum_q   <= '0;
        end else begin
            b_valid_q <= accept;
            b_bin_q   <= in_bin;
            b_inc_q   <= in_inc;
            c_valid_q <= b_valid_q;
            c_bin_q   <= b_bin_q;
            c_sum_q   <= sum;
            d_valid_q <= c_valid_q;
            d_bin_q   <= c_bin_q;
            d_sum_q   <= c_sum_q;
        end
    end

    // Mode FSM, clear sequencer, host read-return pipe and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StStream;
            target_q  <= StStream;
            clr_cnt_q <= '0;
            ovf_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= host_rd;
            rdv_q     <= rd_pend_q;
            if (rd_pend_q) begin
                rdata_q <= ram_q;
            end
            if (b_valid_q && carry) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                StStream: begin
                    if (clear_req) begin
                        state_q  <= StDrain;
                        target_q <= StClear;
                    end else if (host_sel) begin
                        state_q  <= StDrain;
                        target_q <= StHost;
                    end
                end
                StDrain: begin
                    // A late clear request overrides a pending host handoff.
                    if (clear_req) begin
                        target_q <= StClear;
                    end
                    if (pipe_empty) begin
                        if (clear_req || (target_q == StClear)) begin
                            state_q   <= StClear;
                            clr_cnt_q <= '0;
                            ovf_q     <= 1'b0;
                        end else if (host_sel) begin
                            state_q <= StHost;
                        end else begin
                            state_q <= StStream;
                        end
                    end
                end
                StHost: begin
                    if (clear_req) begin
                        state_q   <= StClear;
                        clr_cnt_q <= '0;
                        ovf_q     <= 1'b0;
                    end else if (!host_sel && !rd_pend_q && !host_rd) begin
                        // Leave only once no read data is still owed to the host.
                        state_q <= StStream;
                    end
                end
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == '1) begin
                        state_q <= host_sel ? StHost : StStream;
                    end
                end
                default: state_q <= StStream;
            endcase
        end
    end

endmodule
